// File: rtl/uart_xcvr_fifo.sv
// uart_xcvr_fifo -- full-duplex UART transceiver with TX and RX FIFOs.
//
// Frame: start bit, DataBits data bits LSB first, optional parity bit, one stop bit.
// Optional feature macro: UART_PARITY_EN (adds a parity bit, even/odd per ParityOdd).
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_i         asynchronous active-high reset
//   rx_i            serial input, idle high, asynchronous to clk_i
//   tx_o            serial output, idle high
//   tx_data_i       byte to transmit
//   tx_valid_i      tx_data_i valid
//   tx_ready_o      TX FIFO not full
//   rx_data_o       head of RX FIFO (0 when empty)
//   rx_valid_o      RX FIFO not empty
//   rx_ready_i      consumer pops rx_data_o
//   rx_frame_err_o  1-cycle pulse: stop bit sampled low
//   rx_parity_err_o 1-cycle pulse: parity mismatch (0 without UART_PARITY_EN)
//   rx_overrun_o    1-cycle pulse: good frame dropped, RX FIFO full
module uart_xcvr_fifo #(
   parameter int ClkFreq   = 12000000,
   parameter int BaudRate  = 115200,
   parameter int DataBits  = 8,
   parameter int FifoDepth = 16,
   parameter int ParityOdd = 0
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                rx_i,
   output logic                tx_o,
   input  logic [DataBits-1:0] tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [DataBits-1:0] rx_data_o,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   output logic                rx_frame_err_o,
   output logic                rx_parity_err_o,
   output logic                rx_overrun_o
);

   localparam int ClksPerBit = (ClkFreq + BaudRate / 2) / BaudRate;
   localparam int CntW = $clog2(ClksPerBit + 1);
   localparam int PtrW = $clog2(FifoDepth);
   localparam int IdxW = $clog2(DataBits);
   localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DataBits - 1);
   localparam logic [PtrW:0]   PtrOne  = (PtrW + 1)'(1);

`ifdef UART_PARITY_EN
   localparam logic ParBit = ParityOdd[0];
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
`else
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
`endif

   // ---------------- TX FIFO ----------------
   logic [DataBits-1:0] tx_mem [FifoDepth];
   logic [PtrW:0]       tx_wr, tx_rd;
   logic                tx_full, tx_empty, tx_push, tx_pop;
   logic [DataBits-1:0] tx_head;

   assign tx_full    = (tx_wr[PtrW] != tx_rd[PtrW]) && (tx_wr[PtrW-1:0] == tx_rd[PtrW-1:0]);
   assign tx_empty   = (tx_wr == tx_rd);
   assign tx_ready_o = ~tx_full;
   assign tx_push    = tx_valid_i & ~tx_full;
   assign tx_head    = tx_mem[tx_rd[PtrW-1:0]];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + PtrOne;
         if (tx_pop)  tx_rd <= tx_rd + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr[PtrW-1:0]] <= tx_data_i;
   end

   // ---------------- TX FSM ----------------
   tx_state_t           tx_state, tx_next;
   logic [CntW-1:0]     tx_cnt;
   logic [IdxW-1:0]     tx_idx;
   logic [DataBits-1:0] tx_shift;
   logic                tx_bit_done, tx_line;
`ifdef UART_PARITY_EN
   logic                tx_par;
`endif

   assign tx_bit_done = (tx_cnt == LastCnt);

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop  = 1'b1;
               tx_next = TX_START;
            end
         end
         TX_START: begin
            tx_line = 1'b0;
            if (tx_bit_done) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_shift[0];
            if (tx_bit_done && tx_idx == LastIdx)
`ifdef UART_PARITY_EN
               tx_next = TX_PARITY;
`else
               tx_next = TX_STOP;
`endif
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            tx_line = tx_par;
            if (tx_bit_done) tx_next = TX_STOP;
         end
`endif
         TX_STOP: begin
            // Next frame starts straight out of STOP so there is no idle gap.
            if (tx_bit_done) begin
               if (!tx_empty) begin
                  tx_pop  = 1'b1;
                  tx_next = TX_START;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // tx_o is registered, so the line lags the state by one cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_o     <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_next;
         tx_o     <= tx_line;
         if (tx_next != tx_state || tx_bit_done || tx_state == TX_IDLE)
            tx_cnt <= '0;
         else
            tx_cnt <= tx_cnt + CntW'(1);
         if (tx_pop) begin
            tx_shift <= tx_head;
            tx_idx   <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head ^ ParBit;
`endif
         end else if (tx_state == TX_DATA && tx_bit_done) begin
            tx_shift <= tx_shift >> 1;
            tx_idx   <= tx_idx + IdxW'(1);
         end
      end
   end

   // ---------------- RX FSM ----------------
   rx_state_t           rx_state, rx_next;
   logic [1:0]          rx_sync;
   logic                rx_s;
   logic [CntW-1:0]     rx_cnt;
   logic [IdxW-1:0]     rx_idx;
   logic [DataBits-1:0] rx_shift;
   logic                rx_bit_done, rx_stop_smp, rx_par_bad, rx_wr_pend;

   assign rx_s        = rx_sync[1];
   assign rx_bit_done = (rx_cnt == LastCnt);
   assign rx_stop_smp = (rx_state == RX_STOP) && rx_bit_done;

`ifdef UART_PARITY_EN
   logic rx_par_bit;
   assign rx_par_bad = ((^rx_shift ^ rx_par_bit) != ParBit);
`else
   assign rx_par_bad = 1'b0;
   // No parity bit in this build; ParityOdd has no effect.
   assign rx_parity_err_o = 1'b0 & ParityOdd[0];
`endif

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         // Mid-start sample high means a glitch; drop back silently.
         RX_START: if (rx_cnt == HalfCnt) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA: begin
            if (rx_bit_done && rx_idx == LastIdx)
`ifdef UART_PARITY_EN
               rx_next = RX_PARITY;
`else
               rx_next = RX_STOP;
`endif
         end
`ifdef UART_PARITY_EN
         RX_PARITY: if (rx_bit_done) rx_next = RX_STOP;
`endif
         RX_STOP:  if (rx_bit_done) rx_next = rx_s ? RX_IDLE : RX_BREAK;
         RX_BREAK: if (rx_s) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [DataBits-1:0] rx_mem [FifoDepth];
   logic [PtrW:0]       rx_wr, rx_rd;
   logic                rx_full, rx_push, rx_pop;

   assign rx_full    = (rx_wr[PtrW] != rx_rd[PtrW]) && (rx_wr[PtrW-1:0] == rx_rd[PtrW-1:0]);
   assign rx_valid_o = (rx_wr != rx_rd);
   assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd[PtrW-1:0]] : '0;
   // Fullness is judged before any same-cycle pop.
   assign rx_push    = rx_wr_pend & ~rx_full;
   assign rx_pop     = rx_valid_o & rx_ready_i;

   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem[rx_wr[PtrW-1:0]] <= rx_shift;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_sync        <= '1;
         rx_state       <= RX_IDLE;
         rx_cnt         <= '0;
         rx_idx         <= '0;
         rx_shift       <= '0;
         rx_wr_pend     <= 1'b0;
         rx_frame_err_o <= 1'b0;
         rx_overrun_o   <= 1'b0;
         rx_wr          <= '0;
         rx_rd          <= '0;
`ifdef UART_PARITY_EN
         rx_par_bit      <= 1'b0;
         rx_parity_err_o <= 1'b0;
`endif
      end else begin
         rx_sync  <= {rx_sync[0], rx_i};
         rx_state <= rx_next;
         if (rx_next != rx_state || rx_bit_done || rx_state == RX_IDLE || rx_state == RX_BREAK)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + CntW'(1);
         if (rx_state == RX_START) rx_idx <= '0;
         if (rx_state == RX_DATA && rx_bit_done) begin
            rx_shift <= {rx_s, rx_shift[DataBits-1:1]};
            rx_idx   <= rx_idx + IdxW'(1);
         end
`ifdef UART_PARITY_EN
         if (rx_state == RX_PARITY && rx_bit_done) rx_par_bit <= rx_s;
         rx_parity_err_o <= rx_stop_smp & rx_s & rx_par_bad;
`endif
         rx_frame_err_o <= rx_stop_smp & ~rx_s;
         rx_wr_pend     <= rx_stop_smp & rx_s & ~rx_par_bad;
         rx_overrun_o   <= rx_wr_pend & rx_full;
         if (rx_push) rx_wr <= rx_wr + PtrOne;
         if (rx_pop)  rx_rd <= rx_rd + PtrOne;
      end
   end

endmodule

// File: tb/tb_uart_xcvr_fifo.sv
// tb_uart_xcvr_fifo -- self-checking bench for uart_xcvr_fifo at default parameters.
// Honours UART_PARITY_EN the same way the design does.
module tb_uart_xcvr_fifo;

   localparam int CPB = 104;
`ifdef UART_PARITY_EN
   localparam int   NB      = 11;
   localparam logic PAR_ODD = 1'b0;
`else
   localparam int   NB      = 10;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_o, tx_ready, rx_valid, fe, pe, ov, rx_line;
   logic [7:0] rx_data;

   int         vectors = 0;
   int         miscompares = 0;
   int         n_fe = 0, n_pe = 0, n_ov = 0;
   int         s_fe, s_pe, s_ov;
   logic [7:0] exp_q [$];

   assign rx_line = loop_en ? tx_o : rx_drv;

   always #5 clk = ~clk;

   uart_xcvr_fifo #(
      .ClkFreq(12000000), .BaudRate(115200), .DataBits(8), .FifoDepth(16), .ParityOdd(0)
   ) dut (
      .clk_i(clk), .reset_i(reset), .rx_i(rx_line), .tx_o(tx_o),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .rx_frame_err_o(fe), .rx_parity_err_o(pe), .rx_overrun_o(ov)
   );

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Error-pulse tally and RX scoreboard: every pop is checked against the queue.
   always @(negedge clk) begin
      if (fe) n_fe++;
      if (pe) n_pe++;
      if (ov) n_ov++;
      if (!reset && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) chk(32'(exp_q.size()), 32'd1, "rx_unexpected_byte");
         else chk(32'(rx_data), 32'(exp_q.pop_front()), "rx_data");
      end
   end

   function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic stop);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef UART_PARITY_EN
      f[9]   = ^d ^ PAR_ODD;
      f[10]  = stop;
`else
      f[9]   = stop;
`endif
      return f;
   endfunction

   task automatic snap();
      s_fe = n_fe; s_pe = n_pe; s_ov = n_ov;
   endtask

   task automatic push_tx(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
      if (n >= 20000) chk(32'(tx_ready), 32'd1, "push_ready_timeout");
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [11:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         rx_drv = f[i];
         repeat (CPB) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   // Push one byte into an idle transmitter and check tx_o on every cycle.
   task automatic tx_wave(input logic [7:0] b, input string tag);
      logic [11:0] f;
      logic        e;
      f = mk_frame(b, 1'b1);
      push_tx(b);
      for (int c = 0; c < NB * CPB + 20; c++) begin
         if (c < 2 || c >= 2 + NB * CPB) e = 1'b1;
         else e = f[(c - 2) / CPB];
         chk(32'(tx_o), 32'(e), tag);
         @(negedge clk);
      end
   endtask

   task automatic wait_q_empty(input int bound, input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
      chk(32'(exp_q.size()), 32'd0, tag);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk(32'(tx_o), 32'd1, "rst_tx_o");
      chk(32'(tx_ready), 32'd1, "rst_tx_ready");
      chk(32'(rx_valid), 32'd0, "rst_rx_valid");
      chk(32'(rx_data), 32'd0, "rst_rx_data");
      chk(32'({fe, pe, ov}), 32'd0, "rst_err_pulses");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk(32'(tx_o), 32'd1, "idle_tx_o");

      // TX waveform of 0x55
      tx_wave(8'h55, "tx_wave_55");
      chk(32'(tx_ready), 32'd1, "tx_ready_after_55");

      // Loopback of three bytes
      loop_en  = 1'b1;
      rx_ready = 1'b1;
      snap();
      exp_q.push_back(8'hA5); push_tx(8'hA5);
      exp_q.push_back(8'h3C); push_tx(8'h3C);
      exp_q.push_back(8'hFF); push_tx(8'hFF);
      wait_q_empty(4 * NB * CPB, "loop_drain");
      chk(32'(n_fe - s_fe + n_pe - s_pe + n_ov - s_ov), 32'd0, "loop_no_errors");

      // Frame with stop bit low
      repeat (CPB) @(negedge clk);
      loop_en = 1'b0;
      repeat (20) @(negedge clk);
      snap();
      send_bits(mk_frame(8'h81, 1'b0), NB);
      repeat (300) @(negedge clk);
      chk(32'(n_fe - s_fe), 32'd1, "frame_err_pulses");
      chk(32'(n_pe - s_pe + n_ov - s_ov), 32'd0, "frame_err_others");
      chk(32'(rx_valid), 32'd0, "frame_err_no_byte");
      chk(32'(rx_data), 32'd0, "frame_err_rx_data");

      // Overrun: 17 frames into a 16-entry RX FIFO with no consumer
      rx_ready = 1'b0;
      loop_en  = 1'b1;
      snap();
      for (int i = 0; i < 17; i++) begin
         chk(32'(tx_ready), 32'd1, "ovr_tx_ready");
         if (i < 16) exp_q.push_back(8'(8'h60 + i));
         push_tx(8'(8'h60 + i));
      end
      begin
         int n = 0;
         while (n_ov == s_ov && n < 20000) begin @(negedge clk); n++; end
      end
      repeat (1200) @(negedge clk);
      chk(32'(n_ov - s_ov), 32'd1, "ovr_pulses");
      chk(32'(n_fe - s_fe), 32'd0, "ovr_no_frame_err");
      chk(32'(rx_valid), 32'd1, "ovr_rx_valid");
      chk(32'(exp_q.size()), 32'd16, "ovr_queue_pending");
      rx_ready = 1'b1;
      wait_q_empty(100, "ovr_drain");
      repeat (5) @(negedge clk);
      chk(32'(rx_valid), 32'd0, "ovr_empty_after_drain");

      // Short low glitch, then a clean 0x42
      loop_en = 1'b0;
      repeat (20) @(negedge clk);
      snap();
      rx_drv = 1'b0;
      repeat (30) @(negedge clk);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk);
      chk(32'(n_fe - s_fe + n_pe - s_pe + n_ov - s_ov), 32'd0, "glitch_no_flag");
      chk(32'(rx_valid), 32'd0, "glitch_no_byte");
      exp_q.push_back(8'h42);
      send_bits(mk_frame(8'h42, 1'b1), NB);
      wait_q_empty(300, "after_glitch_42");
      chk(32'(n_fe - s_fe), 32'd0, "after_glitch_no_fe");

      // Reset in the middle of 0xF0 with three bytes queued
      push_tx(8'hF0);
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      repeat (297) @(negedge clk);
      chk(32'(tx_o), 32'd0, "mid_tx_data_bit");
      chk(32'(tx_ready), 32'd1, "mid_tx_ready");
      reset = 1'b1;
      #1;
      chk(32'(tx_o), 32'd1, "rst_async_tx_o");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk(32'(tx_ready), 32'd1, "post_rst_tx_ready");
      chk(32'(rx_valid), 32'd0, "post_rst_rx_valid");
      for (int i = 0; i < 200; i++) begin
         chk(32'(tx_o), 32'd1, "post_rst_idle");
         @(negedge clk);
      end
      tx_wave(8'h55, "post_rst_wave_55");

`ifdef UART_PARITY_EN
      // Parity generation and RX parity mismatch
      tx_wave(8'h07, "par_tx_07");
      snap();
      send_bits(mk_frame(8'h5A, 1'b1) ^ 12'h200, NB);
      repeat (200) @(negedge clk);
      chk(32'(n_pe - s_pe), 32'd1, "par_err_pulses");
      chk(32'(n_fe - s_fe), 32'd0, "par_err_no_fe");
      chk(32'(rx_valid), 32'd0, "par_err_no_byte");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
